// File: rtl/fp_pkg.sv
// Shared single-precision datapath constants and types.
// Used by the aligner, the normalizer and the mantissa adder.
package fp_pkg;

   localparam int EXP_W     = 8;
   localparam int MANT_W    = 23;
   localparam int ALIGN_MAX = 26;
   localparam int GRS_W     = 3;
   localparam int WORD_W    = 1 + EXP_W + MANT_W;
   localparam int SIG_W     = MANT_W + 1;
   localparam int ALN_W     = SIG_W + GRS_W;
   localparam int CNT_W     = 5;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } align_state_e;

   // One right-shift step; bits leaving [1] fold into the sticky bit [0].
   function automatic logic [ALN_W-1:0] shr_sticky(input logic [ALN_W-1:0] v);
      return {1'b0, v[ALN_W-1:2], v[1] | v[0]};
   endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits a binary32 word into sign, effective exponent and hidden-bit mantissa.
// Denormals read as exponent 1 with a zero hidden bit.
module fp_unpack
   import fp_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   output logic              sign,
   output logic [EXP_W-1:0]  eff_exp,
   output logic [SIG_W-1:0]  mant
);

   logic [EXP_W-1:0] exp_f;
   logic             hidden;

   assign sign    = word[WORD_W-1];
   assign exp_f   = word[WORD_W-2 -: EXP_W];
   assign hidden  = |exp_f;
   assign eff_exp = hidden ? exp_f : EXP_W'(1);
   assign mant    = {hidden, word[MANT_W-1:0]};

endmodule

// File: rtl/fp_mant_align.sv
// Serial exponent aligner: shifts the smaller mantissa right one bit per cycle
// until it shares the larger exponent, collecting guard/round/sticky.
module fp_mant_align
   import fp_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] a,
   input  logic [WORD_W-1:0] b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [EXP_W-1:0]  exp_out,
   output logic              sign_big,
   output logic              sign_small,
   output logic [SIG_W-1:0]  mant_big,
   output logic [ALN_W-1:0]  mant_small,
   output logic              swapped
);

   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [SIG_W-1:0] a_mant, b_mant;

   fp_unpack u_unpack_a (.word(a), .sign(a_sign), .eff_exp(a_exp), .mant(a_mant));
   fp_unpack u_unpack_b (.word(b), .sign(b_sign), .eff_exp(b_exp), .mant(b_mant));

   // Compare / swap; ties keep a as the big operand.
   logic             a_big;
   logic [EXP_W-1:0] diff;
   logic [CNT_W-1:0] sh_cnt;

   assign a_big  = (a_exp >= b_exp);
   assign diff   = a_big ? (a_exp - b_exp) : (b_exp - a_exp);
   assign sh_cnt = (diff > EXP_W'(ALIGN_MAX)) ? CNT_W'(ALIGN_MAX) : diff[CNT_W-1:0];

   align_state_e     state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             load, step;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               load      = 1'b1;
               state_nxt = (sh_cnt == '0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            step = 1'b1;
            if (cnt == CNT_W'(1)) state_nxt = DONE;
         end
         DONE: begin
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) out_valid <= 1'b0;
      else        out_valid <= (state_nxt == DONE);
   end

   // Data registers only move on acceptance and shift steps, so DONE holds them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         exp_out    <= '0;
         sign_big   <= 1'b0;
         sign_small <= 1'b0;
         mant_big   <= '0;
         mant_small <= '0;
         swapped    <= 1'b0;
      end else if (load) begin
         cnt        <= sh_cnt;
         exp_out    <= a_big ? a_exp : b_exp;
         sign_big   <= a_big ? a_sign : b_sign;
         sign_small <= a_big ? b_sign : a_sign;
         mant_big   <= a_big ? a_mant : b_mant;
         mant_small <= {(a_big ? b_mant : a_mant), GRS_W'(0)};
         swapped    <= ~a_big;
      end else if (step) begin
         cnt        <= cnt - CNT_W'(1);
         mant_small <= shr_sticky(mant_small);
      end
   end

endmodule

// File: doc/fp_mant_align.md
# fp_mant_align

Serial exponent-alignment stage for the single-precision adder path of the Maxnet datapath. It is the right-shift counterpart of the post-add normalizer: it takes two IEEE-754 binary32 operands and selects the larger exponent. It then shifts the smaller operand's mantissa right one bit per cycle until both operands share that exponent, collecting guard/round/sticky bits. Results are passed downstream over a valid/ready handshake to the mantissa adder.

## Interface
- No parameters. Widths come from the shared package: EXP_W=8, MANT_W=23, ALIGN_MAX=26.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept a pair
- a, b  in  32 each  binary32 operands
- out_valid  out  1  aligned result valid
- out_ready  in  1  downstream accepts result
- exp_out  out  8  common (larger effective) exponent
- sign_big, sign_small  out  1 each  signs of the larger- and smaller-exponent operands
- mant_big  out  24  larger operand mantissa with hidden bit
- mant_small  out  27  aligned smaller mantissa: [26:3] mantissa, [2] guard, [1] round, [0] sticky
- swapped  out  1  1 when b was selected as the larger operand

## Operation
- Unpack each operand into sign, exponent and hidden-bit mantissa.
  - Effective exponent = 1 when the exponent field is 0; otherwise it equals the exponent field.
  - Hidden bit = (exp field != 0).
- Selection:
  - a is "big" if eff_exp(a) >= eff_exp(b), and swapped=0.
  - Otherwise b is big and swapped=1.
  - Ties choose a.
- diff = eff_exp(big) - eff_exp(small), an 8-bit unsigned value.
- Shift count = min(diff, ALIGN_MAX).
- Initial small vector = {hidden, mant, 3'b000}.
- One shift step: new[26]=0, new[25:1]=old[26:2], new[0]=old[1]|old[0]. Sticky is sticky-OR: once set it stays set.
- FSM:
  - IDLE: in_ready=1. On in_valid, latch all fields and load the counter. Go to DONE if count==0, otherwise go to SHIFT.
  - SHIFT: each cycle apply one shift step and decrement the counter. When the counter is 1, the step is taken and the state moves to DONE.
  - DONE: out_valid=1 and the outputs are held stable. On out_ready, go to IDLE.
- in_ready=0 in SHIFT and DONE. There is no overlap of consecutive operations.
- NaN and Inf get no special handling; the bits pass through by the same rules. Special-case handling is downstream.
- Reset values: state=IDLE, in_ready=1, out_valid=0. All data outputs are 0, including exp_out, mant_big, mant_small, signs and swapped.

## Timing
- Latency from the acceptance edge (in_valid & in_ready) to out_valid high = shift count + 1 cycles. The range is 1..27.
- out_valid is registered. Data outputs change only on the acceptance edge and on SHIFT edges, never while in DONE.
- When out_valid & out_ready occur on the same edge, the block returns to IDLE. in_ready rises on the next cycle, so back-to-back throughput is at least count+2 cycles.
- in_valid is ignored outside IDLE, and the operand inputs are not sampled there.
- An rst_n assertion in any state asynchronously forces reset values. A partially shifted result is discarded, not emitted.
- diff > ALIGN_MAX: after 26 steps every nonzero bit of the small mantissa has collapsed into [0]. There is no further shifting.

## Structure
- Shared package fp_pkg holds the following, reused by the normalizer and the adder:
  - EXP_W, MANT_W, ALIGN_MAX, the GRS width (3)
  - the state enum {IDLE, SHIFT, DONE}
- One natural sub-module, fp_unpack: combinational. It maps a 32-bit word to sign, eff_exp and a 24-bit hidden-bit mantissa, and is instantiated twice.
- Top level contains the compare/swap logic, a 5-bit shift counter, the 27-bit shift register and the FSM.

## Test plan
- a=0x3F800000, b=0x3F800000:
  - out_valid exactly 1 cycle after acceptance.
  - exp_out=127, mant_big=0x800000, mant_small=0x4000000, swapped=0.
- a=0x3F800000, b=0x3F000000 (diff 1):
  - latency 2
  - exp_out=127, mant_small=0x2000000, sticky=0
- a=0x3F000000, b=0x40400000 (diff 2):
  - swapped=1, sign_big=0, exp_out=128, mant_big=0xC00000
  - mant_small=0x1000000, latency 3
- a=0x4F800000, b=0x3F800001 (diff 32, capped):
  - latency 27, mant_small=27'h0000001
  - in_ready stays 0 throughout
- Backpressure: hold out_ready=0 for 5 cycles in DONE. All outputs must stay stable and in_valid must be ignored. Then pulse out_ready for 1 cycle: in_ready=1 on the next cycle.
- Reset mid-SHIFT: drop rst_n during a diff-10 operation. All outputs go to their reset values immediately, with no out_valid pulse. After release, a fresh diff-0 pair completes in 1 cycle.
